// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset vector, addressing-mode and fetch-state encodings
package fetch_unit_pkg;
  localparam int REG_WIDTH = 8;
  localparam int MEM_ADDR_WIDTH = 16;
  localparam logic [MEM_ADDR_WIDTH-1:0] INSTRUCTION_BASE = 16'hC000;
  typedef enum logic [3:0] {
    AM_IMPL, AM_IMM, AM_ZPG, AM_ZPG_X, AM_ZPG_Y, AM_ABS, AM_ABS_X,
    AM_ABS_Y, AM_X_IND, AM_IND_Y, AM_IND, AM_REL
  } am_t;
  typedef enum logic [2:0] {IDLE, OPC, OP_LO, OP_HI, PTR_LO, PTR_HI, DONE} state_t;
endpackage

// File: rtl/am_decode.sv
// am_decode: 6502 opcode to addressing mode and operand byte count
module am_decode
  import fetch_unit_pkg::*;
(
  input  logic [7:0] opcode,
  output am_t        mode,
  output logic [1:0] nbytes
);
  logic [1:0] cc;
  logic [2:0] bbb;
  logic y_swap;
  assign cc = opcode[1:0];
  assign bbb = opcode[4:2];
  // LDX/STX index by Y where the rest of group 10 uses X
  assign y_swap = opcode == 8'h96 || opcode == 8'hB6 || opcode == 8'hBE;
  always_comb begin
    mode = AM_IMPL;
    case (cc)
      2'b01:
        case (bbb)
          3'd0: mode = AM_X_IND;
          3'd1: mode = AM_ZPG;
          3'd2: mode = AM_IMM;
          3'd3: mode = AM_ABS;
          3'd4: mode = AM_IND_Y;
          3'd5: mode = AM_ZPG_X;
          3'd6: mode = AM_ABS_Y;
          3'd7: mode = AM_ABS_X;
        endcase
      2'b10:
        case (bbb)
          3'd0: mode = AM_IMM;
          3'd1: mode = AM_ZPG;
          3'd3: mode = AM_ABS;
          3'd5: mode = y_swap ? AM_ZPG_Y : AM_ZPG_X;
          3'd7: mode = y_swap ? AM_ABS_Y : AM_ABS_X;
          default: mode = AM_IMPL;
        endcase
      2'b00:
        case (bbb)
          3'd0: mode = opcode == 8'h20 ? AM_ABS : opcode[7:5] > 3'd4 ? AM_IMM : AM_IMPL;
          3'd1: mode = AM_ZPG;
          3'd3: mode = opcode == 8'h6C ? AM_IND : AM_ABS;
          3'd4: mode = AM_REL;
          3'd5: mode = AM_ZPG_X;
          3'd7: mode = AM_ABS_X;
          default: mode = AM_IMPL;
        endcase
      default: mode = AM_IMPL;
    endcase
  end
  assign nbytes = mode == AM_IMPL ? 2'd0 :
                  mode inside {AM_ABS, AM_ABS_X, AM_ABS_Y, AM_IND} ? 2'd2 : 2'd1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: 6502-style instruction fetch with addressing-mode decode and
// effective-address generation over a request/valid memory port
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = REG_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(INSTRUCTION_BASE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [3:0]            mode,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic                  page_cross,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  valid,
  input  logic                  ready_in,
  output logic                  busy
);
  localparam int HW = ADDR_WIDTH - 8;
  state_t state, state_d;
  am_t am, rd_am, am_d;
  logic [1:0] nb, rd_nb, nb_d;
  logic [ADDR_WIDTH-1:0] pc, pc_nx, abs_a, ptr_a, base, idx_sum, rel, ea_d;
  logic [DATA_WIDTH-1:0] lo, hi, plo, phi, lo_d, hi_d, plo_d, phi_d;
  logic [7:0] idx, zp_ix, zp_lo, ptr_pg;
  logic page_d, take;
  am_decode u_dec (.opcode(opcode[7:0]), .mode(am), .nbytes(nb));
  am_decode u_dec_rd (.opcode(mem_rdata[7:0]), .mode(rd_am), .nbytes(rd_nb));
  assign take = start && (state == IDLE || (state == DONE && ready_in));
  assign mem_req = state inside {OPC, OP_LO, OP_HI, PTR_LO, PTR_HI};
  assign valid = state == DONE;
  assign busy = state != IDLE;
  assign mode = am;
  // pointer lives in page zero except for JMP (ind), which wraps within its own page
  assign zp_lo = am == AM_X_IND ? lo[7:0] + x_in[7:0] : lo[7:0];
  assign ptr_pg = am == AM_IND ? hi[7:0] : 8'h00;
  assign mem_addr = state == OPC    ? pc :
                    state == OP_LO  ? pc + ADDR_WIDTH'(1) :
                    state == OP_HI  ? pc + ADDR_WIDTH'(2) :
                    state == PTR_LO ? ADDR_WIDTH'({ptr_pg, zp_lo}) :
                    state == PTR_HI ? ADDR_WIDTH'({ptr_pg, 8'(zp_lo + 8'd1)}) : '0;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? OPC : IDLE;
      OPC:     if (mem_rvalid) state_d = rd_nb == 2'd0 ? DONE : OP_LO;
      OP_LO:   if (mem_rvalid) state_d = nb == 2'd2 ? OP_HI :
                                         (am == AM_X_IND || am == AM_IND_Y) ? PTR_LO : DONE;
      OP_HI:   if (mem_rvalid) state_d = am == AM_IND ? PTR_LO : DONE;
      PTR_LO:  if (mem_rvalid) state_d = PTR_HI;
      PTR_HI:  if (mem_rvalid) state_d = DONE;
      DONE:    if (ready_in) state_d = start ? OPC : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // result computed from the byte arriving this cycle so DONE needs no extra cycle
  always_comb begin
    am_d = state == OPC ? rd_am : am;
    nb_d = state == OPC ? rd_nb : nb;
    lo_d = state == OP_LO ? mem_rdata : lo;
    hi_d = state == OP_HI ? mem_rdata : hi;
    plo_d = state == PTR_LO ? mem_rdata : plo;
    phi_d = state == PTR_HI ? mem_rdata : phi;
    pc_nx = pc + ADDR_WIDTH'(nb_d) + ADDR_WIDTH'(1);
    abs_a = ADDR_WIDTH'({hi_d[7:0], lo_d[7:0]});
    ptr_a = ADDR_WIDTH'({phi_d[7:0], plo_d[7:0]});
    idx = (am_d == AM_ABS_X || am_d == AM_ZPG_X) ? x_in[7:0] : y_in[7:0];
    zp_ix = lo_d[7:0] + idx;
    base = am_d == AM_IND_Y ? ptr_a : abs_a;
    idx_sum = base + ADDR_WIDTH'(idx);
    rel = pc_nx + {{HW{lo_d[7]}}, lo_d[7:0]};
    ea_d = '0;
    page_d = 1'b0;
    case (am_d)
      AM_IMM:                       ea_d = pc + ADDR_WIDTH'(1);
      AM_ZPG:                       ea_d = ADDR_WIDTH'(lo_d[7:0]);
      AM_ZPG_X, AM_ZPG_Y:           ea_d = ADDR_WIDTH'(zp_ix);
      AM_ABS:                       ea_d = abs_a;
      AM_X_IND, AM_IND:             ea_d = ptr_a;
      AM_ABS_X, AM_ABS_Y, AM_IND_Y: begin
        ea_d = idx_sum;
        page_d = idx_sum[ADDR_WIDTH-1:8] != base[ADDR_WIDTH-1:8];
      end
      AM_REL: begin
        ea_d = rel;
        page_d = rel[ADDR_WIDTH-1:8] != pc_nx[ADDR_WIDTH-1:8];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc <= '0;
      opcode <= '0;
      lo <= '0;
      hi <= '0;
      plo <= '0;
      phi <= '0;
      ea <= '0;
      page_cross <= 1'b0;
      pc_next <= RESET_PC;
    end else begin
      state <= state_d;
      if (take) pc <= pc_in;
      if (mem_rvalid && state == OPC) opcode <= mem_rdata;
      if (mem_rvalid) begin
        lo <= lo_d;
        hi <= hi_d;
        plo <= plo_d;
        phi <= phi_d;
      end
      if (state != DONE && state_d == DONE) begin
        ea <= ea_d;
        page_cross <= page_d;
        pc_next <= pc_nx;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetches against a wait-state memory model, results checked through a scoreboard
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, ready_in = 1'b0;
  logic mem_req, mem_rvalid, page_cross, valid, busy;
  logic [15:0] pc_in = '0, mem_addr, ea, pc_next;
  logic [7:0] x_in = '0, y_in = '0, mem_rdata, opcode;
  logic [3:0] mode;
  logic [7:0] mem [0:65535];
  int waits = 0, wcnt = 0, compared = 0, mismatched = 0;
  typedef struct {
    string tag;
    logic [7:0] opc;
    logic [3:0] md;
    logic [15:0] ea;
    logic pcx;
    logic [15:0] pcn;
    int lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pc_in(pc_in), .x_in(x_in), .y_in(y_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .opcode(opcode), .mode(mode), .ea(ea), .page_cross(page_cross), .pc_next(pc_next),
    .valid(valid), .ready_in(ready_in), .busy(busy)
  );

  assign mem_rvalid = mem_req && wcnt == waits;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk or negedge reset_n)
    if (!reset_n) wcnt <= 0;
    else if (mem_req) wcnt <= mem_rvalid ? 0 : wcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic fetch(input string tag, input logic [15:0] pc, input int w, input logic [7:0] opc,
                       input logic [3:0] md, input logic [15:0] e_a, input logic pcx,
                       input logic [15:0] pcn, input int lat, input bit hold, input bit poke);
    exp_t e, got;
    int n;
    e.tag = tag; e.opc = opc; e.md = md; e.ea = e_a; e.pcx = pcx; e.pcn = pcn; e.lat = lat;
    sb.push_back(e);
    waits = w;
    @(negedge clk);
    pc_in = pc;
    start = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready_in = 1'b0;
    n = 1;
    while (!valid && n < 200) begin
      start = poke;
      if (poke) pc_in = 16'h1111;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    got = sb.pop_front();
    chk({got.tag, " latency"}, n, got.lat);
    chk({got.tag, " opcode"}, opcode, got.opc);
    chk({got.tag, " mode"}, mode, got.md);
    chk({got.tag, " ea"}, ea, got.ea);
    chk({got.tag, " page_cross"}, page_cross, got.pcx);
    chk({got.tag, " pc_next"}, pc_next, got.pcn);
    chk({got.tag, " mem_req in done"}, mem_req, 1'b0);
    if (!hold) begin
      @(negedge clk);
      chk({got.tag, " valid held"}, valid, 1'b1);
      ready_in = 1'b1;
      @(negedge clk);
      ready_in = 1'b0;
      chk({got.tag, " released"}, {valid, busy}, 2'b00);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    mem[16'h9000] = 8'hBD; mem[16'h9001] = 8'hFF; mem[16'h9002] = 8'h12;
    mem[16'hA000] = 8'hB1; mem[16'hA001] = 8'hFF;
    mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'hB000] = 8'h6C; mem[16'hB001] = 8'hFF; mem[16'hB002] = 8'h10;
    mem[16'h10FF] = 8'h00; mem[16'h1000] = 8'h56; mem[16'h1100] = 8'hEE;
    mem[16'hA100] = 8'hA1; mem[16'hA101] = 8'hFE;
    mem[16'hA200] = 8'hB6; mem[16'hA201] = 8'hF0;
    mem[16'h0100] = 8'hD0; mem[16'h0101] = 8'hFD;
    mem[16'hFFFF] = 8'hE8;
    repeat (3) @(negedge clk);
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset valid", valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset opcode", opcode, 8'h00);
    chk("reset mode", mode, AM_IMPL);
    chk("reset ea", ea, 16'h0000);
    chk("reset page_cross", page_cross, 1'b0);
    chk("reset pc_next", pc_next, INSTRUCTION_BASE);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle no request", {mem_req, busy}, 2'b00);
    fetch("lda_imm", 16'h8000, 0, 8'hA9, AM_IMM, 16'h8001, 1'b0, 16'h8002, 3, 1'b0, 1'b0);
    x_in = 8'h01;
    fetch("lda_absx", 16'h9000, 0, 8'hBD, AM_ABS_X, 16'h1300, 1'b1, 16'h9003, 4, 1'b0, 1'b0);
    fetch("lda_absx_wait", 16'h9000, 1, 8'hBD, AM_ABS_X, 16'h1300, 1'b1, 16'h9003, 7, 1'b0, 1'b1);
    y_in = 8'h10;
    fetch("lda_indy", 16'hA000, 0, 8'hB1, AM_IND_Y, 16'h1244, 1'b0, 16'hA002, 5, 1'b0, 1'b0);
    fetch("jmp_ind", 16'hB000, 0, 8'h6C, AM_IND, 16'h5600, 1'b0, 16'hB003, 6, 1'b0, 1'b0);
    fetch("lda_xind", 16'hA100, 0, 8'hA1, AM_X_IND, 16'h1234, 1'b0, 16'hA102, 5, 1'b0, 1'b0);
    y_in = 8'h20;
    fetch("ldx_zpy", 16'hA200, 0, 8'hB6, AM_ZPG_Y, 16'h0010, 1'b0, 16'hA202, 3, 1'b0, 1'b0);
    fetch("bne_back", 16'h0100, 0, 8'hD0, AM_REL, 16'h00FF, 1'b1, 16'h0102, 3, 1'b1, 1'b0);
    fetch("inx_wrap", 16'hFFFF, 0, 8'hE8, AM_IMPL, 16'h0000, 1'b0, 16'h0000, 2, 1'b0, 1'b0);
    waits = 2;
    @(negedge clk);
    pc_in = 16'h9000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (mem_addr !== 16'h9001 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midfetch op_lo reached", {mem_req, mem_addr}, {1'b1, 16'h9001});
    #1 reset_n = 1'b0;
    #1;
    chk("midfetch reset mem_req", mem_req, 1'b0);
    chk("midfetch reset busy", {busy, valid}, 2'b00);
    chk("midfetch reset pc_next", pc_next, INSTRUCTION_BASE);
    chk("midfetch reset mode", mode, AM_IMPL);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post reset idle", {mem_req, busy}, 2'b00);
    fetch("lda_imm_again", 16'h8000, 0, 8'hA9, AM_IMM, 16'h8001, 1'b0, 16'h8002, 3, 1'b0, 1'b0);
    chk("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: data bus and index register width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16: address width.
REQ-003 The block SHALL have parameter RESET_PC, default `INSTRUCTION_BASE: pc_next value after reset.
REQ-004 The block SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1: request to fetch the instruction at pc_in.
REQ-007 The block SHALL have port pc_in, input, ADDR_WIDTH: opcode address, sampled when start is accepted.
REQ-008 The block SHALL have port x_in, input, DATA_WIDTH: X register value.
REQ-009 The block SHALL have port y_in, input, DATA_WIDTH: Y register value.
REQ-010 The block SHALL have port mem_req, output, 1: read request to memory.
REQ-011 The block SHALL have port mem_addr, output, ADDR_WIDTH: read address, valid while mem_req is high.
REQ-012 The block SHALL have port mem_rdata, input, DATA_WIDTH: read data.
REQ-013 The block SHALL have port mem_rvalid, input, 1: mem_rdata valid; completes the current request.
REQ-014 The block SHALL have port opcode, output, DATA_WIDTH: fetched opcode.
REQ-015 The block SHALL have port mode, output, 4: decoded addressing mode (AM_* encoding).
REQ-016 The block SHALL have port ea, output, ADDR_WIDTH: effective address.
REQ-017 The block SHALL have port page_cross, output, 1: indexing or branch crossed a 256-byte page.
REQ-018 The block SHALL have port pc_next, output, ADDR_WIDTH: address following the last instruction byte.
REQ-019 The block SHALL have port valid, output, 1: opcode, mode, ea, page_cross and pc_next are valid.
REQ-020 The block SHALL have port ready_in, input, 1: consumer accepts the result.
REQ-021 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, OPC, OP_LO, OP_HI, PTR_LO, PTR_HI, DONE.
REQ-023 start SHALL be accepted only in IDLE. Acceptance latches pc_in and moves to OPC; start in any other state SHALL be ignored.
REQ-024 In OPC, OP_LO, OP_HI, PTR_LO and PTR_HI, mem_req=1 and mem_addr SHALL hold stable until mem_rvalid. A state SHALL advance only on mem_rvalid, so memory wait states stretch the fetch without limit.
REQ-025 mode SHALL be decoded from opcode[1:0] and opcode[4:2], using the standard 6502 cc/bbb groups:
- IMM, ZPG, ZPG_X, ZPG_Y, ABS, ABS_X, ABS_Y, X_IND, IND_Y, IND (0x6C only), REL (opcode[4:0]=10000), IMPL.
- Group 10 index X SHALL become Y for opcodes 0x96, 0xB6 and 0xBE.
REQ-026 Operand byte count SHALL be: IMPL 0; IMM/ZPG*/X_IND/IND_Y/REL 1; ABS*/IND 2. pc_next SHALL equal opcode address + 1 + operand count.
REQ-027 Effective address SHALL be computed per mode:
- IMM: ea = opcode address + 1.
- ZPG: ea = {0, op}.
- ZPG_X/ZPG_Y: ea = {0, (op+idx) mod 256}.
- ABS: ea = {hi, lo}.
- ABS_X/ABS_Y: ea = {hi, lo} + idx, with page_cross = carry out of the low byte.
REQ-028 Indirect modes SHALL read the pointer through PTR_LO then PTR_HI:
- X_IND: pointer at (op+X) mod 256; the high byte wraps within page zero.
- IND_Y: pointer at op, with op+1 wrapping in page zero; ea = ptr + Y, with page_cross per REQ-027.
- IND: high byte read from {hi, lo+1 mod 256} (6502 page-wrap behaviour).
REQ-029 REL SHALL set ea = pc_next + sign-extended op, with page_cross when ea[15:8] != pc_next[15:8]. IMPL SHALL set ea = 0 and page_cross = 0.
REQ-030 In DONE, valid=1 and the outputs SHALL hold until ready_in. On ready_in the FSM returns to IDLE; if start is also high that cycle, it SHALL go directly to OPC with the new pc_in.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; 0xFFFF+1 = 0x0000.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE and set mem_req=0, valid=0, busy=0, opcode=0, mode=AM_IMPL, ea=0, page_cross=0 and pc_next=RESET_PC, including mid-fetch. Partial results SHALL be discarded.
REQ-033 After reset_n deasserts, the first possible mem_req SHALL occur one cycle after an accepted start.

Structure
REQ-034 The AM_* mode encodings and the state encodings SHALL live in the shared defines package, alongside `REG_WIDTH and `ADDR_WIDTH.
REQ-035 Opcode-to-mode and operand-count decoding SHALL be a combinational sub-module, am_decode.

Verification
REQ-036 LDA #$42 (A9 42) at 0x8000, zero-wait memory: 2 reads, mode=IMM, ea=0x8001, pc_next=0x8002, valid on cycle 3.
REQ-037 LDA $12FF,X (BD FF 12) with X=0x01: ea=0x1300, page_cross=1, pc_next=+3. With one wait state per read, valid is delayed exactly 3 cycles.
REQ-038 LDA ($FF),Y (B1 FF) with zp[0xFF]=0x34, zp[0x00]=0x12, Y=0x10: ea=0x1244, page_cross=0.
REQ-039 JMP ($10FF) (6C FF 10): high byte read from 0x1000, not 0x1100.
REQ-040 BNE -3 (D0 FD) at 0x0100: ea=0x00FF, page_cross=1. reset_n pulsed during OP_LO of a following fetch: IDLE and mem_req=0 immediately, pc_next=RESET_PC.
